// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and WIDTH bounds.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder; the serial datapath's only arithmetic cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock through a registered-carry full adder.
// Optional macro SERIAL_ADDER_OVF_EN adds a two's-complement overflow output (ovf).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Handshake: start is sampled only in IDLE together with a/b/sub/cin; busy is high for the
  // WIDTH RUN cycles; done pulses one cycle and sum/cout are valid from then until the next done.

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_adder: WIDTH out of legal range");
  end

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             c_next;
  logic             last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  fa_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (s_bit),
    .cout(c_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Subtraction is a + ~b + 1: invert b at load and force the initial carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            sum_sh <= '0;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= c_next;
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            sum  <= {s_bit, sum_sh[WIDTH-1:1]};
            cout <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on the final bit
            ovf  <= carry ^ c_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed/random/handshake/reset, WIDTH=2 exhaustive.
// Honours SERIAL_ADDER_OVF_EN to also check the overflow output.
module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared drive, per-DUT outputs ----------------
  bit         sel;
  logic       start_d, sub_d, cin_d;
  logic [7:0] a_d, b_d;

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;
  logic       ovf8, ovf2;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_d & ~sel), .sub(sub_d), .cin(cin_d),
    .a(a_d), .b(b_d), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_d & sel), .sub(sub_d), .cin(cin_d),
    .a(a_d[1:0]), .b(b_d[1:0]), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf2 = 1'b0;
`endif

  logic       busy_m, done_m, cout_m, ovf_m;
  logic [7:0] sum_m;
  assign busy_m = sel ? busy2 : busy8;
  assign done_m = sel ? done2 : done8;
  assign cout_m = sel ? cout2 : cout8;
  assign ovf_m  = sel ? ovf2  : ovf8;
  assign sum_m  = sel ? {6'b0, sum2} : sum8;

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; result packed as {ovf[9], cout[8], sum[7:0]}.
  function automatic logic [63:0] model(input int w, input longint a, input longint b,
                                        input bit sub, input bit cin);
    longint m, half, am, bb, c, full, sa, sb, st;
    logic [63:0] r;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    am   = a & m;
    bb   = sub ? (~b & m) : (b & m);
    c    = sub ? 1 : longint'(cin);
    full = am + bb + c;
    sa   = (am >= half) ? am - (m + 1) : am;
    sb   = (bb >= half) ? bb - (m + 1) : bb;
    st   = sa + sb + c;
    r    = 64'(full & m);
    r[8] = ((full >> w) & 1) != 0;
    r[9] = (st >= half) || (st < -half);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge with the selected DUT idle; returns at the negedge after the done pulse,
  // so back-to-back calls issue starts at the minimum spacing.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit sub, input bit cin,
                        input bit poke);
    int          w, t, nb;
    logic [63:0] e;
    w       = sel ? 2 : 8;
    a_d     = a;
    b_d     = b;
    sub_d   = sub;
    cin_d   = cin;
    start_d = 1'b1;
    exp_q.push_back(model(w, longint'(a), longint'(b), sub, cin));
    @(negedge clk);
    start_d = 1'b0;
    a_d     = 8'($urandom_range(0, 255));
    b_d     = 8'($urandom_range(0, 255));
    sub_d   = ~sub;
    cin_d   = ~cin;
    check("hold_sum", {56'b0, sum_m}, {56'b0, last_res[sel][7:0]});
    check("hold_cout", {63'b0, cout_m}, {63'b0, last_res[sel][8]});
    t  = 0;
    nb = 0;
    while (!done_m && t < w + 4) begin
      if (busy_m) nb++;
      start_d = poke && (t == 3);
      @(negedge clk);
      t++;
    end
    start_d = 1'b0;
    check("latency", 64'(t), 64'(w));
    check("busy_cycles", 64'(nb), 64'(w));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sum", {56'b0, sum_m}, {56'b0, e[7:0]});
      check("cout", {63'b0, cout_m}, {63'b0, e[8]});
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", {63'b0, ovf_m}, {63'b0, e[9]});
`endif
      last_res[sel] = e;
    end
    @(negedge clk);
    check("done_pulse", {63'b0, done_m}, 64'd0);
    check("busy_idle", {63'b0, busy_m}, 64'd0);
  endtask

  // Reset four cycles into RUN: outputs clear at once and the aborted operation never completes.
  task automatic reset_mid_run();
    int n_done;
    a_d     = 8'h5A;
    b_d     = 8'h33;
    sub_d   = 1'b0;
    cin_d   = 1'b1;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    for (int t = 0; t < 4; t++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", {63'b0, busy8}, 64'd0);
    check("rst_done", {63'b0, done8}, 64'd0);
    check("rst_sum", {56'b0, sum8}, 64'd0);
    check("rst_cout", {63'b0, cout8}, 64'd0);
    check("rst_ovf", {63'b0, ovf8}, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    n_done   = 0;
    for (int t = 0; t < 12; t++) begin
      if (done8 || busy8) n_done++;
      @(negedge clk);
    end
    check("rst_no_done", 64'(n_done), 64'd0);
    last_res[0] = '0;
    last_res[1] = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sel         = 1'b0;
    start_d     = 1'b0;
    sub_d       = 1'b0;
    cin_d       = 1'b0;
    a_d         = '0;
    b_d         = '0;
    last_res[0] = '0;
    last_res[1] = '0;
    rst         = 1'b1;
    #12;
    check("init_busy", {63'b0, busy8}, 64'd0);
    check("init_done", {63'b0, done8}, 64'd0);
    check("init_sum", {56'b0, sum8}, 64'd0);
    check("init_cout", {63'b0, cout8}, 64'd0);
    check("init_ovf", {63'b0, ovf8}, 64'd0);
    check("init_sum2", {62'b0, sum2}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(8'h10, 8'h01, 1'b1, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    run_op(8'hC3, 8'h69, 1'b0, 1'b1, 1'b1);
    run_op(8'h21, 8'h9E, 1'b1, 1'b0, 1'b1);

    reset_mid_run();

    for (int i = 0; i < 30; i++)
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    sel = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          for (int c = 0; c < 2; c++)
            run_op(8'(a), 8'(b), 1'(s), 1'(c), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle, bit-serial adder/subtractor, the successor to the single-bit combinational full adder.
- Processes one operand bit per clock through a single registered-carry full-adder cell, LSB first, with a start/busy/done handshake.
- Used where area matters more than latency, and as the building block for later serial multiplier and accumulator blocks.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 2..64.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request a new operation; sampled only in IDLE.
- sub, input, 1: 0 = add, 1 = subtract (a - b); sampled with start.
- cin, input, 1: carry-in for add; ignored when sub=1; sampled with start.
- a, input, WIDTH: operand A; sampled with start.
- b, input, WIDTH: operand B; sampled with start.
- busy, output, 1: high while an operation is in progress (RUN state).
- done, output, 1: single-cycle pulse; sum/cout are valid from this cycle.
- sum, output, WIDTH: registered result; held until the next completion.
- cout, output, 1: carry-out for add; no-borrow flag for sub (1 = a >= b unsigned).

Behaviour:
- Reset (async assert, rst high): state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers, carry and counter all 0. Reset is released synchronously to clk by the integrator.
- States: IDLE -> RUN -> DONE -> IDLE. Encoding is 2-bit, defined in the package.
- IDLE:
  - start=1 at edge E0 loads A_sh=a.
  - Loads B_sh=b, or ~b when sub=1.
  - Sets carry=cin (add) or 1 (sub), clears internal sum shift register and cnt, then goes to RUN.
  - start=0: stay in IDLE.
- RUN, edges E1..E_WIDTH, one bit per edge:
  - s_i = A_sh[0] ^ B_sh[0] ^ carry.
  - carry <= majority(A_sh[0], B_sh[0], carry).
  - A_sh and B_sh shift right by 1; s_i is shifted into the MSB of the internal sum shift register; cnt increments.
  - At E_WIDTH (cnt == WIDTH-1 before the edge): sum <= final shift-register value, cout <= final carry, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Timing:
  - busy=1 exactly during the WIDTH cycles following E0.
  - done rises in the cycle after E_WIDTH, i.e. WIDTH cycles after start was sampled.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start while in RUN or DONE is ignored; no queuing and no error flag. Changes on a/b/sub/cin after E0 have no effect.
- sum/cout update only at E_WIDTH and hold their value across IDLE and later starts until the next completion.
- Arithmetic is modulo 2^WIDTH.
  - Add: {cout,sum} = a + b + cin.
  - Sub: {cout,sum} = a + ~b + 1.
- Reset mid-operation aborts immediately: all outputs return to reset values and no done pulse is produced.
- cnt width is $clog2(WIDTH); WIDTH=2 must work (cnt is 1 bit).

Optional Feature:
- SERIAL_ADDER_OVF_EN:
  - Defined: adds output port ovf (1 bit), two's-complement signed overflow.
  - ovf = carry into the MSB XOR carry out of the MSB, captured at E_WIDTH with sum.
  - ovf reset value is 0 and it holds like sum.
- Undefined: the ovf port and its logic are absent; nothing else changes.

Decomposition:
- Package serial_adder_pkg holds:
  - state typedef/localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the WIDTH legality bounds, with an elaboration-time check.
- Sub-module fa_cell is a purely combinational 1-bit full adder with ports a, b, cin, s, cout.
  - It is instantiated once; the carry register lives in serial_adder.

Test Plan:
- Basic add: WIDTH=8, a=0x5A, b=0x33, cin=0, sub=0, start pulse -> busy high 8 cycles, done pulse on cycle 8, sum=0x8D, cout=0.
- Carry wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Subtract: a=0x10, b=0x01, sub=1, cin=1 (ignored) -> sum=0x0F, cout=1. Then a=0x00, b=0x01 -> sum=0xFF, cout=0.
- Overflow (macro defined): a=0x7F, b=0x01 add -> sum=0x80, ovf=1. a=0x80, b=0x01 sub -> sum=0x7F, ovf=1. a=0x05, b=0x03 add -> ovf=0.
- Handshake and reset:
  - start re-pulsed at RUN cycle 3 with different operands -> ignored; the first result completes unchanged.
  - rst asserted at RUN cycle 4 -> busy=0, sum=0, cout=0 immediately, and no done pulse afterwards.
- Exhaustive: WIDTH=2, all 2x4x4x2 (sub, a, b, cin) combinations, back-to-back at minimum spacing -> compare {cout,sum} against the behavioural model each done pulse.
